// File: rtl/pcie_tx_pkg.sv
// Shared constants for the PCIe TX path: AXIS tuser bit positions, FSM encoding, widths.
package pcie_tx_pkg;

  localparam int TUSER_W  = 4;
  localparam int BUF_AV_W = 6;

  localparam int TUSER_ERRFWD      = 1;
  localparam int TUSER_STR         = 2;
  localparam int TUSER_DISCONTINUE = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Index width for n requesters, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational find-first-set starting at index 'first' and wrapping; shared by TX and RX arbiters.
module rr_arbiter_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] first,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(first) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-granular arbiter sharing the pcie_7x AXIS TX port between NUM_REQ sources.
// Build option: PCIE_TX_ARB_FIXED_PRIO_EN gives requester 0 strict priority instead of round-robin.
module pcie_tx_arbiter
  import pcie_tx_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int MIN_BUF_AV = 2,
  localparam int ID_W      = id_width(NUM_REQ)
) (
  input  logic                          user_clk,
  input  logic                          user_reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0] s_tkeep,
  input  logic [NUM_REQ*TUSER_W-1:0]    s_tuser,
  input  logic [NUM_REQ-1:0]            s_tlast,
  input  logic [NUM_REQ-1:0]            s_tvalid,
  output logic [NUM_REQ-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic [KEEP_WIDTH-1:0]         m_tkeep,
  output logic [TUSER_W-1:0]            m_tuser,
  output logic                          m_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  input  logic [BUF_AV_W-1:0]           tx_buf_av,
  input  logic                          tx_cfg_req,
  output logic                          tx_cfg_gnt,
  output logic [ID_W-1:0]               grant_id
);

  logic [0:0]      state;
  logic            busy;
  logic            start;
  logic            pkt_end;
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic [ID_W-1:0] first_idx;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] tdata_a;
  logic [NUM_REQ-1:0][KEEP_WIDTH-1:0] tkeep_a;
  logic [NUM_REQ-1:0][TUSER_W-1:0]    tuser_a;

  assign tdata_a = s_tdata;
  assign tkeep_a = s_tkeep;
  assign tuser_a = s_tuser;

  assign busy = (state == ST_BUSY);

`ifdef PCIE_TX_ARB_FIXED_PRIO_EN
  assign first_idx = '0;
`else
  logic [ID_W-1:0] ptr;

  assign first_idx = (ptr == ID_W'(NUM_REQ - 1)) ? '0 : ptr + ID_W'(1);

  always_ff @(posedge user_clk) begin
    if (user_reset)
      ptr <= '0;
    else if (busy && pkt_end)
      ptr <= grant_id;
  end
`endif

  rr_arbiter_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (s_tvalid),
    .first (first_idx),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Config traffic from the core beats user requesters; buffer space only gates packet starts.
  assign start = !busy && pick_found && !tx_cfg_req &&
                 (tx_buf_av >= BUF_AV_W'(MIN_BUF_AV));

  assign pkt_end = m_tvalid && m_tready && m_tlast;

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state    <= ST_IDLE;
      grant_id <= '0;
    end else if (start) begin
      state    <= ST_BUSY;
      grant_id <= pick_idx;
    end else if (busy && pkt_end) begin
      state    <= ST_IDLE;
    end
  end

  // Zero-latency pass-through of the granted slice; nothing is buffered.
  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tuser  = '0;
    m_tlast  = 1'b0;
    m_tvalid = 1'b0;
    if (busy) begin
      m_tdata  = tdata_a[grant_id];
      m_tkeep  = tkeep_a[grant_id];
      m_tuser  = tuser_a[grant_id];
      m_tlast  = s_tlast[grant_id];
      m_tvalid = s_tvalid[grant_id];
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign s_tready[i] = busy && (grant_id == ID_W'(i)) && m_tready;
  end

  assign tx_cfg_gnt = !busy;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Randomized bench for pcie_tx_arbiter: a cycle-level reference model feeds a scoreboard queue.
module tb_pcie_tx_arbiter;
  localparam int N    = 2;
  localparam int DW   = 64;
  localparam int KW   = 8;
  localparam int MINB = 2;
  localparam int IDW  = 1;

  logic            user_clk = 1'b0;
  logic            user_reset = 1'b1;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N*KW-1:0] s_tkeep = '0;
  logic [N*4-1:0]  s_tuser = '0;
  logic [N-1:0]    s_tlast = '0;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic [3:0]      m_tuser;
  logic            m_tlast;
  logic            m_tvalid;
  logic            m_tready = 1'b0;
  logic [5:0]      tx_buf_av = 6'd32;
  logic            tx_cfg_req = 1'b0;
  logic            tx_cfg_gnt;
  logic [IDW-1:0]  grant_id;

  pcie_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MIN_BUF_AV(MINB)) dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .tx_buf_av(tx_buf_av), .tx_cfg_req(tx_cfg_req), .tx_cfg_gnt(tx_cfg_gnt),
    .grant_id(grant_id)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic          gnt;
    logic          vld;
    logic [N-1:0]  rdy;
    logic [IDW-1:0] gid;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [3:0]    user;
    logic          last;
    logic          zero;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   started = 0;

  // Requester-side packet state
  bit            has_pkt[N];
  int            left[N];
  logic [DW-1:0] cd[N];
  logic [KW-1:0] ck[N];
  logic [3:0]    cu[N];

  // Reference model: owner is the last granted requester, ptr the round-robin origin
  bit busy_m = 0;
  int own_m = 0;
  int ptr_m = 0;
  bit post_rst = 1;

  int gen_pct = 0, vld_pct = 0, rdy_pct = 100, lmin = 1, lmax = 1;
  int cfg_pct = 0, rst_pct = 100, buf_lo = 32, buf_hi = 32;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic new_beat(input int i);
    cd[i] = {$urandom, $urandom};
    ck[i] = KW'($urandom);
    cu[i] = 4'($urandom);
  endtask

  function automatic int pick();
`ifdef PCIE_TX_ARB_FIXED_PRIO_EN
    for (int j = 0; j < N; j++) if (s_tvalid[j]) return j;
`else
    for (int k = 1; k <= N; k++) if (s_tvalid[(ptr_m + k) % N]) return (ptr_m + k) % N;
`endif
    return 0;
  endfunction

  task automatic step();
    exp_t e;
    @(posedge user_clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (!has_pkt[i] && $urandom_range(99) < gen_pct) begin
        has_pkt[i] = 1;
        left[i] = $urandom_range(lmax, lmin);
        new_beat(i);
      end
      s_tvalid[i] = has_pkt[i] && ($urandom_range(99) < vld_pct);
      s_tlast[i] = has_pkt[i] && (left[i] == 1);
      s_tdata[i*DW +: DW] = cd[i];
      s_tkeep[i*KW +: KW] = ck[i];
      s_tuser[i*4 +: 4] = cu[i];
    end
    m_tready   = $urandom_range(99) < rdy_pct;
    tx_cfg_req = $urandom_range(99) < cfg_pct;
    tx_buf_av  = 6'($urandom_range(buf_hi, buf_lo));
    user_reset = $urandom_range(99) < rst_pct;

    e.gnt  = !busy_m;
    e.vld  = busy_m && s_tvalid[own_m];
    e.rdy  = '0;
    if (busy_m && m_tready) e.rdy[own_m] = 1'b1;
    e.gid  = IDW'(own_m);
    e.data = cd[own_m];
    e.keep = ck[own_m];
    e.user = cu[own_m];
    e.last = has_pkt[own_m] && (left[own_m] == 1);
    e.zero = post_rst;
    exp_q.push_back(e);
    started = 1;

    post_rst = 0;
    if (user_reset) begin
      busy_m = 0; own_m = 0; ptr_m = 0; post_rst = 1;
      for (int i = 0; i < N; i++) has_pkt[i] = 0;
    end else if (!busy_m) begin
      if (|s_tvalid && !tx_cfg_req && int'(tx_buf_av) >= MINB) begin
        own_m = pick();
        busy_m = 1;
      end
    end else if (s_tvalid[own_m] && m_tready) begin
      left[own_m]--;
      if (left[own_m] == 0) begin
        has_pkt[own_m] = 0;
        busy_m = 0;
`ifndef PCIE_TX_ARB_FIXED_PRIO_EN
        ptr_m = own_m;
`endif
      end else begin
        new_beat(own_m);
      end
    end
  endtask

  // Monitor: one expected record per cycle, sampled on the falling edge
  always @(negedge user_clk) begin
    exp_t e;
    if (started) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty actual=0 expected=1 t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("m_tvalid", 64'(m_tvalid), 64'(e.vld));
        chk("s_tready", 64'(s_tready), 64'(e.rdy));
        chk("tx_cfg_gnt", 64'(tx_cfg_gnt), 64'(e.gnt));
        chk("grant_id", 64'(grant_id), 64'(e.gid));
        if (e.vld) begin
          chk("m_tdata", m_tdata, e.data);
          chk("m_tkeep", 64'(m_tkeep), 64'(e.keep));
          chk("m_tuser", 64'(m_tuser), 64'(e.user));
          chk("m_tlast", 64'(m_tlast), 64'(e.last));
        end
        if (e.zero) begin
          chk("rst_m_tdata", m_tdata, 64'd0);
          chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
          chk("rst_m_tuser", 64'(m_tuser), 64'd0);
          chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      has_pkt[i] = 0; left[i] = 0; cd[i] = '0; ck[i] = '0; cu[i] = '0;
    end
    repeat (3) step();
    rst_pct = 0;
    repeat (2) step();
    // Both requesters saturating with 3-beat packets
    gen_pct = 100; vld_pct = 100; lmin = 3; lmax = 3;
    repeat (24) step();
    // Backpressure on 4-beat packets
    rdy_pct = 50; lmin = 4; lmax = 4;
    repeat (40) step();
    // Core config request landing mid-packet
    rdy_pct = 100; lmin = 5; lmax = 5;
    repeat (3) step();
    cfg_pct = 100;
    repeat (10) step();
    cfg_pct = 0;
    repeat (5) step();
    // Drain, then starve the TX buffer count
    gen_pct = 0;
    repeat (12) step();
    gen_pct = 100; buf_lo = 1; buf_hi = 1;
    repeat (5) step();
    buf_lo = 2; buf_hi = 2;
    repeat (6) step();
    // Reset pulse mid-packet, then fresh traffic
    buf_lo = 32; buf_hi = 32; lmin = 4; lmax = 4;
    repeat (4) step();
    rst_pct = 100;
    step();
    rst_pct = 0;
    repeat (12) step();
    // Random mix
    gen_pct = 40; vld_pct = 80; rdy_pct = 70; lmin = 1; lmax = 5;
    cfg_pct = 5; rst_pct = 1; buf_lo = 0; buf_hi = 8;
    repeat (3000) step();

    @(negedge user_clk);
    #1;
    started = 0;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
